// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshakes on both sides.
// Optional completed-result counter enabled by defining LOGIC_UNIT_PIPE_OPCNT_EN.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] Y,
  output logic             ZERO,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [15:0]      OP_CNT
);

  typedef enum logic [2:0] {
    OpAnd  = 3'b000,
    OpOr   = 3'b001,
    OpNor  = 3'b010,
    OpInv  = 3'b011,
    OpXor  = 3'b100,
    OpNand = 3'b101,
    OpXnor = 3'b110,
    OpPass = 3'b111
  } op_e;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  op_e              s1_op_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] y_q;
  logic             zero_q;

  logic             s2_load;
  logic             s1_load;
  logic [WIDTH-1:0] res;
  logic             res_zero;

  // S2 frees up when empty or draining; S1 may refill whenever S2 takes its content.
  assign s2_load  = !s2_valid_q || OUT_READY;
  assign s1_load  = !s1_valid_q || s2_load;
  assign IN_READY = s1_load;

  always_comb begin
    res = '0;
    unique case (s1_op_q)
      OpAnd:   res = s1_a_q & s1_b_q;
      OpOr:    res = s1_a_q | s1_b_q;
      OpNor:   res = ~(s1_a_q | s1_b_q);
      OpInv:   res = ~s1_a_q;
      OpXor:   res = s1_a_q ^ s1_b_q;
      OpNand:  res = ~(s1_a_q & s1_b_q);
      OpXnor:  res = ~(s1_a_q ^ s1_b_q);
      OpPass:  res = s1_a_q;
      default: res = '0;
    endcase
    res_zero = (res == '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      zero_q     <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= IN_VALID;
      end
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        // A bubble advancing leaves the last result visible.
        if (s1_valid_q) begin
          y_q    <= res;
          zero_q <= res_zero;
        end
      end
    end
  end

  // Operand registers need no reset: their contents only matter while s1_valid_q is set.
  always_ff @(posedge CLK) begin
    if (!RST && s1_load && IN_VALID) begin
      s1_a_q  <= A;
      s1_b_q  <= B;
      s1_op_q <= op_e'(OP);
    end
  end

  assign Y         = y_q;
  assign ZERO      = zero_q;
  assign OUT_VALID = s2_valid_q;

`ifdef LOGIC_UNIT_PIPE_OPCNT_EN
  logic [15:0] op_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_cnt_q <= 16'h0000;
    end else if (s2_valid_q && OUT_READY) begin
      op_cnt_q <= op_cnt_q + 16'd1;
    end
  end

  assign OP_CNT = op_cnt_q;
`else
  assign OP_CNT = 16'h0000;
`endif

endmodule
